// File: rtl/wb_stage_mlane_pkg.sv
// wb_stage_mlane_pkg: lane field layout, packing widths and exception codes for the multi-lane writeback stage
package wb_stage_mlane_pkg;
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam int ESUB_LSB = 0;
  localparam int ECODE_LSB = 9;
  localparam int EX_BIT = 15;
  localparam int WE_BIT = 16;
  localparam int RES_LSB = 17;
  function automatic int dest_lsb(input int xlen);
    return RES_LSB + xlen;
  endfunction
  function automatic int pc_lsb(input int xlen);
    return RES_LSB + xlen + 5;
  endfunction
  function automatic int lane_w(input int xlen);
    return 2 * xlen + 22;
  endfunction
  function automatic int fwd_w(input int xlen);
    return xlen + 5;
  endfunction
  function automatic int data_w(input int lanes, input int xlen);
    return lanes * lane_w(xlen);
  endfunction
endpackage

// File: rtl/wb_stage_mlane_if.sv
// wb_stage_mlane_if: MEM->WB group handshake in; RF write ports, debug trace, per-lane forwarding and exception report out
interface wb_stage_mlane_if #(
  parameter int LANES = 2,
  parameter int RF_PORTS = 1,
  parameter int XLEN = 32
);
  import wb_stage_mlane_pkg::*;
  logic                              MEM_to_WB_valid;
  logic [data_w(LANES, XLEN)-1:0]    to_WB_data;
  logic                              WB_allow_in;
  logic [RF_PORTS-1:0]               rf_we;
  logic [RF_PORTS*5-1:0]             rf_waddr;
  logic [RF_PORTS*XLEN-1:0]          rf_wdata;
  logic [RF_PORTS*XLEN-1:0]          debug_wb_pc;
  logic [RF_PORTS*4-1:0]             debug_wb_rf_we;
  logic [RF_PORTS*5-1:0]             debug_wb_rf_wnum;
  logic [RF_PORTS*XLEN-1:0]          debug_wb_rf_wdata;
  logic [LANES*fwd_w(XLEN)-1:0]      WB_forward;
  logic                              wb_ex;
  logic [5:0]                        wb_ecode;
  logic [8:0]                        wb_esubcode;
  logic [XLEN-1:0]                   wb_pc;
  modport master (
    output MEM_to_WB_valid, to_WB_data,
    input  WB_allow_in, rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum,
           debug_wb_rf_wdata, WB_forward, wb_ex, wb_ecode, wb_esubcode, wb_pc
  );
  modport slave (
    input  MEM_to_WB_valid, to_WB_data,
    output WB_allow_in, rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum,
           debug_wb_rf_wdata, WB_forward, wb_ex, wb_ecode, wb_esubcode, wb_pc
  );
endinterface

// File: rtl/wb_stage_mlane_picker.sv
// wb_port_picker: pending_i lanes -> up to RF_PORTS one-hot picks (pick_o[0] = oldest) and their union picked_o
module wb_port_picker
  import wb_stage_mlane_pkg::*;
#(
  parameter int LANES = 2,
  parameter int RF_PORTS = 1
) (
  input  logic [LANES-1:0]                pending_i,
  output logic [RF_PORTS-1:0][LANES-1:0]  pick_o,
  output logic [LANES-1:0]                picked_o
);
  logic [LANES-1:0] rem;
  always_comb begin
    rem = pending_i;
    for (int p = 0; p < RF_PORTS; p++) begin
      pick_o[p] = rem & (~rem + LANES'(1));
      rem = rem & ~pick_o[p];
    end
    picked_o = pending_i & ~rem;
  end
endmodule

// File: rtl/wb_stage_mlane.sv
// wb_stage_mlane: multi-lane writeback stage (clk, reset, bus.slave: group in, RF/debug/forward/exception out)
module wb_stage_mlane
  import wb_stage_mlane_pkg::*;
#(
  parameter int LANES = 2,
  parameter int RF_PORTS = 1,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  wb_stage_mlane_if.slave bus
);
  localparam int LW = lane_w(XLEN);
  localparam int FW = fwd_w(XLEN);
  localparam int DL = dest_lsb(XLEN);
  localparam int PL = pc_lsb(XLEN);
  logic                           valid_q, valid_d;
  logic [LANES*LW-1:0]            data_q, data_d;
  logic [LANES-1:0]               pending_q, pending_d;
  logic [LANES-1:0]               commit_in, commit_v, picked;
  logic [RF_PORTS-1:0][LANES-1:0] pick;
  logic                           blk_in, ex_any, ready_go, accept;
  logic [LW-1:0]                  exl_lane;
  wb_port_picker #(.LANES(LANES), .RF_PORTS(RF_PORTS)) u_picker (
    .pending_i(pending_q),
    .pick_o   (pick),
    .picked_o (picked)
  );
  // commit_in ranks the incoming group; commit_v re-derives the same mask from the held group for forwarding
  always_comb begin
    blk_in = 1'b0;
    ex_any = 1'b0;
    commit_in = '0;
    commit_v = '0;
    exl_lane = data_q[LW-1:0];
    for (int i = 0; i < LANES; i++) begin
      blk_in = blk_in | bus.to_WB_data[i*LW+EX_BIT];
      commit_in[i] = bus.to_WB_data[i*LW+WE_BIT] & ~blk_in;
      commit_v[i] = data_q[i*LW+WE_BIT] & ~ex_any & ~data_q[i*LW+EX_BIT];
      exl_lane = (data_q[i*LW+EX_BIT] & ~ex_any) ? data_q[i*LW+:LW] : exl_lane;
      ex_any = ex_any | data_q[i*LW+EX_BIT];
    end
    ready_go = valid_q & ~|(pending_q & ~picked);
    bus.WB_allow_in = ~valid_q | ready_go;
    bus.wb_ex = ready_go & ex_any;
    bus.wb_ecode = ex_any ? exl_lane[ECODE_LSB+:6] : 6'd0;
    bus.wb_esubcode = ex_any ? exl_lane[ESUB_LSB+:9] : 9'd0;
    bus.wb_pc = exl_lane[PL+:XLEN];
    accept = bus.MEM_to_WB_valid & bus.WB_allow_in & ~bus.wb_ex;
    valid_d = accept | (valid_q & ~ready_go);
    pending_d = accept ? commit_in : pending_q & ~picked;
    data_d = accept ? bus.to_WB_data : data_q;
    bus.rf_we = '0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    bus.debug_wb_pc = '0;
    bus.debug_wb_rf_we = '0;
    for (int p = 0; p < RF_PORTS; p++) begin
      bus.rf_we[p] = valid_q & |pick[p];
      bus.debug_wb_rf_we[p*4+:4] = {4{bus.rf_we[p]}};
      for (int i = 0; i < LANES; i++) begin
        bus.rf_waddr[p*5+:5] |= {5{pick[p][i]}} & data_q[i*LW+DL+:5];
        bus.rf_wdata[p*XLEN+:XLEN] |= {XLEN{pick[p][i]}} & data_q[i*LW+RES_LSB+:XLEN];
        bus.debug_wb_pc[p*XLEN+:XLEN] |= {XLEN{pick[p][i]}} & data_q[i*LW+PL+:XLEN];
      end
    end
    bus.debug_wb_rf_wnum = bus.rf_waddr;
    bus.debug_wb_rf_wdata = bus.rf_wdata;
    bus.WB_forward = '0;
    for (int i = 0; i < LANES; i++)
      bus.WB_forward[i*FW+:FW] = {(valid_q & commit_v[i]) ? data_q[i*LW+DL+:5] : 5'd0,
                                  data_q[i*LW+RES_LSB+:XLEN]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      pending_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_wb_stage_mlane.sv
// tb_wb_stage_mlane: directed scoreboard bench over three lane/port configurations of wb_stage_mlane
module tb_wb_stage_mlane;
  import wb_stage_mlane_pkg::*;
  localparam int X = 32;
  localparam int LW = lane_w(X);
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [36:0] qa[$], qb[$], qc[$];
  logic [36:0] ea, eb, ec;
  always #5 clk = ~clk;
  wb_stage_mlane_if #(.LANES(2), .RF_PORTS(2), .XLEN(X)) ifa ();
  wb_stage_mlane_if #(.LANES(2), .RF_PORTS(1), .XLEN(X)) ifb ();
  wb_stage_mlane_if #(.LANES(4), .RF_PORTS(1), .XLEN(X)) ifc ();
  wb_stage_mlane #(.LANES(2), .RF_PORTS(2), .XLEN(X)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  wb_stage_mlane #(.LANES(2), .RF_PORTS(1), .XLEN(X)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  wb_stage_mlane #(.LANES(4), .RF_PORTS(1), .XLEN(X)) dut_c (.clk(clk), .reset(reset), .bus(ifc));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [LW-1:0] mk(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r,
                                       input logic we, input logic ex, input logic [5:0] ecd, input logic [8:0] es);
    return {pc, d, r, we, ex, ecd, es};
  endfunction
  always @(negedge clk)
    for (int p = 0; p < 2; p++)
      if (ifa.rf_we[p]) begin
        if (qa.size() > 0) ea = qa.pop_front(); else ea = '1;
        chk("a_write", {ifa.rf_waddr[p*5+:5], ifa.rf_wdata[p*32+:32]}, ea);
      end
  always @(negedge clk)
    if (ifb.rf_we[0]) begin
      if (qb.size() > 0) eb = qb.pop_front(); else eb = '1;
      chk("b_write", {ifb.rf_waddr, ifb.rf_wdata}, eb);
    end
  always @(negedge clk)
    if (ifc.rf_we[0]) begin
      if (qc.size() > 0) ec = qc.pop_front(); else ec = '1;
      chk("c_write", {ifc.rf_waddr, ifc.rf_wdata}, ec);
    end
  initial begin
    ifa.MEM_to_WB_valid = 1'b0;
    ifb.MEM_to_WB_valid = 1'b0;
    ifc.MEM_to_WB_valid = 1'b0;
    ifa.to_WB_data = '0;
    ifb.to_WB_data = '0;
    ifc.to_WB_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_we", ifa.rf_we, 0);
    chk("rst_a_allow", ifa.WB_allow_in, 1);
    chk("rst_b_we", ifb.rf_we, 0);
    chk("rst_c_ex", ifc.wb_ex, 0);
    chk("rst_c_fwd", |ifc.WB_forward, 0);
    reset = 1'b0;
    @(negedge clk);
    ifa.to_WB_data = {mk(32'h1004, 5'd5, 32'h22, 1'b1, 1'b0, 6'h0, 9'h0), mk(32'h1000, 5'd4, 32'h11, 1'b1, 1'b0, 6'h0, 9'h0)};
    ifa.MEM_to_WB_valid = 1'b1;
    qa.push_back({5'd4, 32'h11});
    qa.push_back({5'd5, 32'h22});
    @(negedge clk);
    ifa.MEM_to_WB_valid = 1'b0;
    chk("t1_we", ifa.rf_we, 2'b11);
    chk("t1_allow", ifa.WB_allow_in, 1);
    chk("t1_dbg_we", ifa.debug_wb_rf_we, 8'hff);
    chk("t1_dbg_pc1", ifa.debug_wb_pc[63:32], 32'h1004);
    chk("t1_fwd0", ifa.WB_forward[36:0], {5'd4, 32'h11});
    chk("t1_fwd1", ifa.WB_forward[73:37], {5'd5, 32'h22});
    @(negedge clk);
    chk("t1_idle_we", ifa.rf_we, 0);
    chk("t1_idle_fwd0", ifa.WB_forward[36:32], 0);
    ifb.to_WB_data = {mk(32'h1004, 5'd5, 32'h22, 1'b1, 1'b0, 6'h0, 9'h0), mk(32'h1000, 5'd4, 32'h11, 1'b1, 1'b0, 6'h0, 9'h0)};
    ifb.MEM_to_WB_valid = 1'b1;
    qb.push_back({5'd4, 32'h11});
    qb.push_back({5'd5, 32'h22});
    @(negedge clk);
    ifb.MEM_to_WB_valid = 1'b0;
    chk("t2_c1_we", ifb.rf_we, 1);
    chk("t2_c1_allow", ifb.WB_allow_in, 0);
    chk("t2_c1_pc", ifb.debug_wb_pc, 32'h1000);
    @(negedge clk);
    chk("t2_c2_we", ifb.rf_we, 1);
    chk("t2_c2_allow", ifb.WB_allow_in, 1);
    chk("t2_c2_fwd1", ifb.WB_forward[73:69], 5);
    @(negedge clk);
    chk("t2_c3_we", ifb.rf_we, 0);
    ifb.to_WB_data = {mk(32'h1104, 5'd9, 32'h99, 1'b0, 1'b0, 6'h0, 9'h0), mk(32'h1100, 5'd8, 32'h88, 1'b0, 1'b0, 6'h0, 9'h0)};
    ifb.MEM_to_WB_valid = 1'b1;
    @(negedge clk);
    ifb.MEM_to_WB_valid = 1'b0;
    chk("t3_we", ifb.rf_we, 0);
    chk("t3_allow", ifb.WB_allow_in, 1);
    chk("t3_fwd0", ifb.WB_forward[36:32], 0);
    chk("t3_ex", ifb.wb_ex, 0);
    for (int i = 0; i < 4; i++)
      ifc.to_WB_data[i*LW+:LW] = mk(32'(32'h2000 + 4 * i), 5'(8 + i), 32'(32'ha0 + i), 1'b1, (i == 2),
                                    (i == 2) ? ECODE_SYS : 6'h0, (i == 2) ? 9'h5 : 9'h0);
    ifc.MEM_to_WB_valid = 1'b1;
    qc.push_back({5'd8, 32'ha0});
    qc.push_back({5'd9, 32'ha1});
    @(negedge clk);
    ifc.MEM_to_WB_valid = 1'b0;
    chk("t4_c1_we", ifc.rf_we, 1);
    chk("t4_c1_ex", ifc.wb_ex, 0);
    chk("t4_c1_allow", ifc.WB_allow_in, 0);
    chk("t4_c1_fwd0", ifc.WB_forward[36:32], 8);
    chk("t4_c1_fwd2", ifc.WB_forward[110:106], 0);
    chk("t4_c1_fwd3", ifc.WB_forward[147:143], 0);
    @(negedge clk);
    chk("t4_c2_we", ifc.rf_we, 1);
    chk("t4_c2_ex", ifc.wb_ex, 1);
    chk("t4_c2_pc", ifc.wb_pc, 32'h2008);
    chk("t4_c2_ecode", ifc.wb_ecode, 6'hb);
    chk("t4_c2_esub", ifc.wb_esubcode, 9'h5);
    chk("t4_c2_allow", ifc.WB_allow_in, 1);
    for (int i = 0; i < 4; i++)
      ifc.to_WB_data[i*LW+:LW] = mk(32'(32'h2100 + 4 * i), 5'(20 + i), 32'(32'hc0 + i), 1'b1, 1'b0, 6'h0, 9'h0);
    ifc.MEM_to_WB_valid = 1'b1;
    @(negedge clk);
    ifc.MEM_to_WB_valid = 1'b0;
    chk("t4_c3_we", ifc.rf_we, 0);
    chk("t4_c3_ex", ifc.wb_ex, 0);
    chk("t4_c3_fwd0", ifc.WB_forward[36:32], 0);
    @(negedge clk);
    chk("t4_c4_we", ifc.rf_we, 0);
    for (int i = 0; i < 4; i++)
      ifc.to_WB_data[i*LW+:LW] = mk(32'(32'h3000 + 4 * i), 5'(12 + i), 32'(32'hd0 + i), 1'b1, (i == 0),
                                    (i == 0) ? ECODE_SYS : 6'h0, 9'h0);
    ifc.MEM_to_WB_valid = 1'b1;
    @(negedge clk);
    ifc.MEM_to_WB_valid = 1'b0;
    chk("t5_we", ifc.rf_we, 0);
    chk("t5_ex", ifc.wb_ex, 1);
    chk("t5_ecode", ifc.wb_ecode, 6'hb);
    chk("t5_esub", ifc.wb_esubcode, 0);
    chk("t5_pc", ifc.wb_pc, 32'h3000);
    @(negedge clk);
    chk("t5_ex_off", ifc.wb_ex, 0);
    for (int k = 0; k < 3; k++) begin
      ifa.to_WB_data = {mk(32'(32'h4004 + 8 * k), 5'(11 + 2 * k), 32'(32'h100 + k), 1'b1, 1'b0, 6'h0, 9'h0),
                        mk(32'(32'h4000 + 8 * k), 5'(10 + 2 * k), 32'(32'h200 + k), 1'b1, 1'b0, 6'h0, 9'h0)};
      ifa.MEM_to_WB_valid = 1'b1;
      qa.push_back({5'(10 + 2 * k), 32'(32'h200 + k)});
      qa.push_back({5'(11 + 2 * k), 32'(32'h100 + k)});
      @(negedge clk);
      chk("t6_we", ifa.rf_we, 2'b11);
      chk("t6_allow", ifa.WB_allow_in, 1);
      chk("t6_fwd0", ifa.WB_forward[36:32], 64'(10 + 2 * k));
    end
    ifa.MEM_to_WB_valid = 1'b0;
    @(negedge clk);
    chk("t6_idle_we", ifa.rf_we, 0);
    ifb.to_WB_data = {mk(32'h5004, 5'd7, 32'h77, 1'b1, 1'b0, 6'h0, 9'h0), mk(32'h5000, 5'd6, 32'h66, 1'b1, 1'b0, 6'h0, 9'h0)};
    ifb.MEM_to_WB_valid = 1'b1;
    qb.push_back({5'd6, 32'h66});
    @(negedge clk);
    ifb.MEM_to_WB_valid = 1'b0;
    chk("t7_c1_we", ifb.rf_we, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t7_rst_we", ifb.rf_we, 0);
    chk("t7_rst_allow", ifb.WB_allow_in, 1);
    chk("t7_rst_ex", ifb.wb_ex, 0);
    chk("t7_rst_fwd1", ifb.WB_forward[73:69], 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t7_after_we", ifb.rf_we, 0);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
